qpsk_dibit_mapper: RTL and testbench

Downstream consumer of the serial bit source in the QPSK transmit chain. Takes one serial bit per enabled clock, hunts for a frame sync word, then groups payload bits into dibits and maps each dibit to a Gray-coded QPSK symbol (I, Q in {+1, −1}) for the modulator. It keeps frame lock with a flywheel over missed sync words and drops back to hunting after repeated misses.

---
 rtl/qpsk_dibit_mapper.sv | 175 +++++++++++++++++
 tb/tb_qpsk_dibit_mapper.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_dibit_mapper.sv
// qpsk_dibit_mapper
// Serial-bit consumer for the QPSK transmit chain. Hunts for an 8-bit frame
// sync word (LSB-first), then groups payload bits into dibits and maps each
// dibit to a Gray-coded QPSK symbol (I, Q in {+1, -1}). Frame lock is kept
// through up to MISS_MAX-1 consecutive bad sync words (flywheel); the
// MISS_MAX-th consecutive miss drops back to hunting.
//
// Handshake: there is no back-pressure. Din is consumed on every posedge CLK
// where EN=1. sym_valid is a one-cycle strobe: when it is high, I_out/Q_out
// carry a new symbol that the modulator must take in that same cycle. The
// symbol values stay held between strobes.
//
// Symbol encoding (two's complement, 2 bits): 2'b01 = +1, 2'b11 = -1.
// The 2'b00 value only appears out of reset, before the first symbol.

module qpsk_dibit_mapper #(
    parameter logic [7:0] SYNC_WORD    = 8'h78,
    parameter int         PAYLOAD_BITS = 8,
    parameter int         MISS_MAX     = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Din,
    input  logic       EN,
    output logic [1:0] I_out,
    output logic [1:0] Q_out,
    output logic       sym_valid,
    output logic       locked,
    output logic       frame_start,
    output logic [1:0] o_dbg_state
);

    // One counter serves both the payload bit index and the 0..7 sync
    // bit index in CHECK, so it must cover the larger of the two ranges.
    localparam int CNT_MAX = (PAYLOAD_BITS > 8) ? PAYLOAD_BITS : 8;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int MW      = $clog2(MISS_MAX + 1);

    localparam logic [CW-1:0] LAST_PAYLOAD = CW'(PAYLOAD_BITS - 1);
    localparam logic [CW-1:0] LAST_SYNC    = CW'(7);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t        r_state,       w_state_nxt;
    logic [7:0]    r_window,      w_window_nxt;
    logic [3:0]    r_fill,        w_fill_nxt;
    logic [CW-1:0] r_bit_cnt,     w_bit_cnt_nxt;
    logic [MW-1:0] r_miss_cnt,    w_miss_cnt_nxt;
    logic          r_i_bit,       w_i_bit_nxt;
    logic [1:0]    r_i_sym,       w_i_sym_nxt;
    logic [1:0]    r_q_sym,       w_q_sym_nxt;
    logic          r_sym_valid,   w_sym_valid_nxt;
    logic          r_frame_start, w_frame_start_nxt;

    // Window contents after shifting in the current bit (first bit ends in [0]).
    logic [7:0] w_window_shift;
    // Fill count after the current bit, saturating at 8.
    logic [3:0] w_fill_inc;

    assign w_window_shift = {Din, r_window[7:1]};
    assign w_fill_inc     = (r_fill >= 4'd8) ? 4'd8 : (r_fill + 4'd1);

    // State register and all datapath registers; outputs come straight from here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= HUNT;
            r_window      <= 8'h00;
            r_fill        <= 4'd0;
            r_bit_cnt     <= '0;
            r_miss_cnt    <= '0;
            r_i_bit       <= 1'b0;
            r_i_sym       <= 2'b00;
            r_q_sym       <= 2'b00;
            r_sym_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_window      <= w_window_nxt;
            r_fill        <= w_fill_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_miss_cnt    <= w_miss_cnt_nxt;
            r_i_bit       <= w_i_bit_nxt;
            r_i_sym       <= w_i_sym_nxt;
            r_q_sym       <= w_q_sym_nxt;
            r_sym_valid   <= w_sym_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    // Next-state and next-datapath logic; EN=0 holds everything, strobes drop.
    always_comb begin
        w_state_nxt       = r_state;
        w_window_nxt      = r_window;
        w_fill_nxt        = r_fill;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_miss_cnt_nxt    = r_miss_cnt;
        w_i_bit_nxt       = r_i_bit;
        w_i_sym_nxt       = r_i_sym;
        w_q_sym_nxt       = r_q_sym;
        w_sym_valid_nxt   = 1'b0;
        w_frame_start_nxt = 1'b0;

        if (EN) begin
            case (r_state)
                HUNT: begin
                    w_window_nxt = w_window_shift;
                    w_fill_nxt   = w_fill_inc;
                    // The fill gate stops a false match on the reset window.
                    if ((w_fill_inc >= 4'd8) && (w_window_shift == SYNC_WORD)) begin
                        w_state_nxt       = PAYLOAD;
                        w_bit_cnt_nxt     = '0;
                        w_miss_cnt_nxt    = '0;
                        w_frame_start_nxt = 1'b1;
                    end
                end

                PAYLOAD: begin
                    if (!r_bit_cnt[0]) begin
                        w_i_bit_nxt = Din;
                    end else begin
                        // Bit 0 maps to +1 (01), bit 1 to -1 (11).
                        w_i_sym_nxt     = {r_i_bit, 1'b1};
                        w_q_sym_nxt     = {Din, 1'b1};
                        w_sym_valid_nxt = 1'b1;
                    end
                    if (r_bit_cnt == LAST_PAYLOAD) begin
                        w_state_nxt   = CHECK;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end

                CHECK: begin
                    w_window_nxt = w_window_shift;
                    if (r_bit_cnt == LAST_SYNC) begin
                        w_bit_cnt_nxt = '0;
                        if (w_window_shift == SYNC_WORD) begin
                            w_state_nxt       = PAYLOAD;
                            w_miss_cnt_nxt    = '0;
                            w_frame_start_nxt = 1'b1;
                        end else if ((int'(r_miss_cnt) + 1) < MISS_MAX) begin
                            // Flywheel: assume the frame is still aligned.
                            w_state_nxt    = PAYLOAD;
                            w_miss_cnt_nxt = r_miss_cnt + 1'b1;
                        end else begin
                            w_state_nxt    = HUNT;
                            w_fill_nxt     = 4'd0;
                            w_miss_cnt_nxt = '0;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = HUNT;
                    w_fill_nxt  = 4'd0;
                end
            endcase
        end
    end

    assign I_out       = r_i_sym;
    assign Q_out       = r_q_sym;
    assign sym_valid   = r_sym_valid;
    assign frame_start = r_frame_start;
    assign locked      = (r_state == PAYLOAD) || (r_state == CHECK);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_qpsk_dibit_mapper.sv
// Directed testbench for qpsk_dibit_mapper. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
module tb_qpsk_dibit_mapper;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic din = 1'b0;
  logic en  = 1'b0;
  logic [1:0] i_out, q_out, dbg_state;
  logic sym_valid, locked, frame_start;

  // second instance, SYNC_WORD = 0
  logic rst_b = 1'b1;
  logic din_b = 1'b0;
  logic en_b  = 1'b0;
  logic [1:0] i_out_b, q_out_b, dbg_state_b;
  logic sym_valid_b, locked_b, frame_start_b;

  qpsk_dibit_mapper dut (
    .CLK         (clk),
    .RST         (rst),
    .Din         (din),
    .EN          (en),
    .I_out       (i_out),
    .Q_out       (q_out),
    .sym_valid   (sym_valid),
    .locked      (locked),
    .frame_start (frame_start),
    .o_dbg_state (dbg_state)
  );

  qpsk_dibit_mapper #(.SYNC_WORD(8'h00)) dut_zero (
    .CLK         (clk),
    .RST         (rst_b),
    .Din         (din_b),
    .EN          (en_b),
    .I_out       (i_out_b),
    .Q_out       (q_out_b),
    .sym_valid   (sym_valid_b),
    .locked      (locked_b),
    .frame_start (frame_start_b),
    .o_dbg_state (dbg_state_b)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_i = 2'b00;  // expected held I symbol
  logic [1:0] exp_q = 2'b00;  // expected held Q symbol

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic b, input logic e);
    @(negedge clk);
    din = b;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  // Eight sync-position bits; checks strobes and lock along the way.
  task automatic send_sync(input string tag, input logic [7:0] word, input logic lk_during,
                           input logic lk_end, input logic fs_end, input logic [1:0] st_end);
    logic [7:0] w;
    w = word;
    for (int k = 0; k < 8; k++) begin
      step(w[k], 1'b1);
      chk({tag, " sym_valid"}, 8'(sym_valid), 8'h00);
      chk({tag, " I hold"}, 8'(i_out), 8'(exp_i));
      chk({tag, " Q hold"}, 8'(q_out), 8'(exp_q));
      if (k < 7) begin
        chk({tag, " frame_start early"}, 8'(frame_start), 8'h00);
        chk({tag, " locked during"}, 8'(locked), 8'(lk_during));
      end else begin
        chk({tag, " frame_start end"}, 8'(frame_start), 8'(fs_end));
        chk({tag, " locked end"}, 8'(locked), 8'(lk_end));
        chk({tag, " state end"}, 8'(dbg_state), 8'(st_end));
      end
    end
  endtask

  // Payload byte 0x78 LSB-first: bits 0,0,0,1,1,1,1,0
  // -> symbols (I,Q) = (01,01) (01,11) (11,11) (11,01).
  task automatic payload_78(input string tag, input logic gap);
    logic [7:0] bits;
    logic [1:0] ei [4];
    logic [1:0] eq [4];
    bits = 8'h78;
    ei = '{2'b01, 2'b01, 2'b11, 2'b11};
    eq = '{2'b01, 2'b11, 2'b11, 2'b01};
    for (int k = 0; k < 8; k++) begin
      step(bits[k], 1'b1);
      if (k % 2 == 1) begin
        exp_i = ei[k / 2];
        exp_q = eq[k / 2];
        chk({tag, " sym_valid Q bit"}, 8'(sym_valid), 8'h01);
      end else begin
        chk({tag, " sym_valid I bit"}, 8'(sym_valid), 8'h00);
      end
      chk({tag, " I_out"}, 8'(i_out), 8'(exp_i));
      chk({tag, " Q_out"}, 8'(q_out), 8'(exp_q));
      chk({tag, " frame_start"}, 8'(frame_start), 8'h00);
      chk({tag, " locked"}, 8'(locked), 8'h01);
      chk({tag, " state"}, 8'(dbg_state), (k == 7) ? 8'(ST_CHECK) : 8'(ST_PAYLOAD));
      if (gap) begin
        step(~bits[k], 1'b0);
        chk({tag, " gap sym_valid"}, 8'(sym_valid), 8'h00);
        chk({tag, " gap I_out"}, 8'(i_out), 8'(exp_i));
        chk({tag, " gap Q_out"}, 8'(q_out), 8'(exp_q));
        chk({tag, " gap frame_start"}, 8'(frame_start), 8'h00);
        chk({tag, " gap locked"}, 8'(locked), 8'h01);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset state
    #12;
    chk("reset I_out", 8'(i_out), 8'h00);
    chk("reset Q_out", 8'(q_out), 8'h00);
    chk("reset sym_valid", 8'(sym_valid), 8'h00);
    chk("reset locked", 8'(locked), 8'h00);
    chk("reset frame_start", 8'(frame_start), 8'h00);
    chk("reset state", 8'(dbg_state), 8'(ST_HUNT));
    @(negedge clk);
    rst = 1'b0;

    // acquire and run two clean frames
    send_sync("acq", 8'h78, 1'b0, 1'b1, 1'b1, ST_PAYLOAD);
    payload_78("pay1", 1'b0);
    send_sync("sync2", 8'h78, 1'b1, 1'b1, 1'b1, ST_PAYLOAD);
    payload_78("pay2", 1'b0);

    // EN toggling 1,0,1,0 through a payload
    send_sync("sync3", 8'h78, 1'b1, 1'b1, 1'b1, ST_PAYLOAD);
    payload_78("pay_gap", 1'b1);

    // one bad sync word: flywheel keeps lock, no frame_start
    send_sync("bad1", 8'h79, 1'b1, 1'b1, 1'b0, ST_PAYLOAD);
    payload_78("pay_fly", 1'b0);
    send_sync("good_after_bad", 8'h78, 1'b1, 1'b1, 1'b1, ST_PAYLOAD);
    payload_78("pay4", 1'b0);

    // two bad sync words in a row: lock drops on the 8th bit of the second
    send_sync("bad2a", 8'h79, 1'b1, 1'b1, 1'b0, ST_PAYLOAD);
    payload_78("pay5", 1'b0);
    send_sync("bad2b", 8'h79, 1'b1, 1'b0, 1'b0, ST_HUNT);
    send_sync("hunt_ff", 8'hFF, 1'b0, 1'b0, 1'b0, ST_HUNT);
    send_sync("reacq", 8'h78, 1'b0, 1'b1, 1'b1, ST_PAYLOAD);
    payload_78("pay6", 1'b0);

    // reset mid-payload after an I bit
    send_sync("sync_pre_rst", 8'h78, 1'b1, 1'b1, 1'b1, ST_PAYLOAD);
    step(1'b0, 1'b1);
    chk("pre-rst I held", 8'(i_out), 8'h03);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst I_out", 8'(i_out), 8'h00);
    chk("async rst Q_out", 8'(q_out), 8'h00);
    chk("async rst locked", 8'(locked), 8'h00);
    chk("async rst state", 8'(dbg_state), 8'(ST_HUNT));
    exp_i = 2'b00;
    exp_q = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1);
    chk("post-rst no half dibit", 8'(sym_valid), 8'h00);
    chk("post-rst locked", 8'(locked), 8'h00);
    chk("post-rst state", 8'(dbg_state), 8'(ST_HUNT));
    send_sync("acq_after_rst", 8'h78, 1'b0, 1'b1, 1'b1, ST_PAYLOAD);

    // SYNC_WORD = 0 instance: zeros from reset lock only on the 8th bit
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      din_b = 1'b0;
      en_b  = 1'b1;
      @(posedge clk);
      #1;
      if (k < 7) begin
        chk("zero-sync frame_start early", 8'(frame_start_b), 8'h00);
        chk("zero-sync locked early", 8'(locked_b), 8'h00);
      end else begin
        chk("zero-sync frame_start 8th", 8'(frame_start_b), 8'h01);
        chk("zero-sync locked 8th", 8'(locked_b), 8'h01);
      end
    end
    chk("zero-sync sym_valid", 8'(sym_valid_b), 8'h00);
    @(negedge clk);
    en_b = 1'b0;
    en   = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
